pc_unit: RTL and testbench

Parametrised program-counter unit for the RISC-V core, replacing the fixed 8-bit PC register. It holds the architectural PC and selects the next PC from sequential, branch, JALR or trap sources. It detects misaligned targets and redirects them to the trap vector while capturing the faulting PC. It also keeps a small return-address stack (RAS) that the fetch stage uses for return prediction.

---
 rtl/pc_pkg.sv | 9 +
 rtl/pc_ras.sv | 50 +++++
 rtl/pc_unit.sv | 72 +++++++
 tb/tb_pc_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants for the program-counter unit: next-PC source encodings
// and the fixed instruction length used for sequential advance.
package pc_pkg;
  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JALR   = 2'b10;
  localparam logic [1:0] PC_SEL_TRAP   = 2'b11;
  localparam int unsigned ILEN_BYTES   = 4;
endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. The top pointer always names the newest
// entry; once full, a push overwrites the oldest slot.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [RAS_DEPTH-1:0][XLEN-1:0] mem;
  logic [PW-1:0] ptr, ptr_nx, ptr_pv;
  logic [CW-1:0] cnt;

  assign ptr_nx = ptr + PW'(1);
  assign ptr_pv = ptr - PW'(1);
  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(RAS_DEPTH));
  assign top    = empty ? '0 : mem[ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && pop && !empty) begin
      mem[ptr] <= din;
    end else if (push) begin
      // Empty push+pop lands here too: it degenerates to a plain push.
      ptr         <= ptr_nx;
      mem[ptr_nx] <= din;
      if (!full) cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr_pv;
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, misaligned-target redirect to the
// trap vector with EPC capture, and the return-address stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] target,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic            misaligned,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            ras_full
);
  logic [XLEN-1:0] cand;
  logic            is_trap, mis_tgt, redirect;

  assign pc_plus4 = pc + XLEN'(ILEN_BYTES);

  always_comb begin
    cand = pc_plus4;
    case (pc_sel)
      PC_SEL_BRANCH: cand = target;
      PC_SEL_JALR:   cand = {target[XLEN-1:1], 1'b0};
      PC_SEL_TRAP:   cand = TRAP_VEC;
      default:       cand = pc_plus4;
    endcase
  end

  assign is_trap  = (pc_sel == PC_SEL_TRAP);
  assign mis_tgt  = ((pc_sel == PC_SEL_BRANCH) || (pc_sel == PC_SEL_JALR)) &&
                    (cand[1:0] != 2'b00);
  assign redirect = is_trap || mis_tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_VEC;
      epc        <= '0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= pc_write && mis_tgt;
      if (pc_write) begin
        pc <= redirect ? TRAP_VEC : cand;
        if (redirect) epc <= pc;
      end
    end
  end

  // Any redirect flushes the stack and suppresses that cycle's push/pop.
  pc_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .rst   (rst),
    .flush (pc_write && redirect),
    .push  (pc_write && !redirect && ras_push),
    .pop   (pc_write && !redirect && ras_pop),
    .din   (pc_plus4),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );
endmodule

// File: tb/tb_pc_unit.sv
// Directed plus randomized bench for pc_unit against a queue-based reference.
module tb_pc_unit;
  localparam int          XLEN  = 32;
  localparam logic [31:0] RVEC  = 32'h0;
  localparam logic [31:0] TVEC  = 32'h100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        pc_write = 1'b0, ras_push = 1'b0, ras_pop = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [31:0] target = '0;
  logic [31:0] pc, pc_plus4, epc, ras_top;
  logic        misaligned, ras_empty, ras_full;

  pc_unit #(.XLEN(XLEN), .RESET_VEC(RVEC), .TRAP_VEC(TVEC), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .pc_sel(pc_sel), .target(target),
    .ras_push(ras_push), .ras_pop(ras_pop), .pc(pc), .pc_plus4(pc_plus4), .epc(epc),
    .misaligned(misaligned), .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // Reference model: architectural values plus a plain queue as the stack.
  logic [31:0] m_pc, m_epc;
  logic        m_mis;
  logic [31:0] m_q[$];

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".pc"}, pc, m_pc);
    cmp({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
    cmp({tag, ".epc"}, epc, m_epc);
    cmp({tag, ".mis"}, {31'b0, misaligned}, {31'b0, m_mis});
    cmp({tag, ".ras_top"}, ras_top, (m_q.size() > 0) ? m_q[$] : 32'h0);
    cmp({tag, ".ras_empty"}, {31'b0, ras_empty}, {31'b0, m_q.size() == 0});
    cmp({tag, ".ras_full"}, {31'b0, ras_full}, {31'b0, m_q.size() == DEPTH});
  endtask

  task automatic model_reset();
    m_pc = RVEC; m_epc = 0; m_mis = 0; m_q.delete();
  endtask

  task automatic model_step(input logic wr, input logic [1:0] sel, input logic [31:0] tgt,
                            input logic push, input logic pop);
    logic [31:0] nxt;
    m_mis = 0;
    if (!wr) return;
    if (sel == 2'd3) begin
      m_epc = m_pc; m_pc = TVEC; m_q.delete();
      return;
    end
    nxt = (sel == 2'd0) ? m_pc + 32'd4 : (sel == 2'd1) ? tgt : (tgt & ~32'd1);
    if (sel != 2'd0 && nxt % 4 != 0) begin
      m_epc = m_pc; m_pc = TVEC; m_mis = 1; m_q.delete();
      return;
    end
    if (push && pop && m_q.size() > 0) m_q[m_q.size()-1] = m_pc + 32'd4;
    else if (push) begin
      m_q.push_back(m_pc + 32'd4);
      if (m_q.size() > DEPTH) void'(m_q.pop_front());
    end else if (pop && m_q.size() > 0) void'(m_q.pop_back());
    m_pc = nxt;
  endtask

  task automatic step(input string tag, input logic wr, input logic [1:0] sel,
                      input logic [31:0] tgt, input logic push, input logic pop);
    @(negedge clk);
    pc_write = wr; pc_sel = sel; target = tgt; ras_push = push; ras_pop = pop;
    @(posedge clk);
    model_step(wr, sel, tgt, push, pop);
    #1 check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; pc_write = 0; ras_push = 0; ras_pop = 0;
    model_reset();
    #2 check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset and sequential advance, then stall.
    do_reset("rst0");
    step("seq1", 1, 0, 0, 0, 0);
    step("seq2", 1, 0, 0, 0, 0);
    step("seq3", 1, 0, 0, 0, 0);
    cmp("seq3.pcC", pc, 32'hC);
    step("stall1", 0, 0, 0, 0, 0);
    step("stall2", 0, 1, 32'h40, 1, 0);
    cmp("stall.pcC", pc, 32'hC);

    // Branch / JALR / misaligned branch.
    step("br40", 1, 1, 32'h40, 0, 0);
    step("jalr81", 1, 2, 32'h81, 0, 0);
    cmp("jalr.pc80", pc, 32'h80);
    step("br42", 1, 1, 32'h42, 0, 0);
    cmp("mis.pulse", {31'b0, misaligned}, 32'd1);
    cmp("mis.epc", epc, 32'h80);
    step("after_mis", 1, 0, 0, 0, 0);
    step("jalr_mis", 1, 2, 32'h53, 1, 0);

    // Trap with two stack entries.
    do_reset("rst1");
    step("b18", 1, 1, 32'h18, 0, 0);
    step("push1c", 1, 0, 0, 1, 0);
    step("push20", 1, 0, 0, 1, 0);
    step("trap", 1, 3, 0, 1, 0);
    cmp("trap.epc", epc, 32'h20);

    // Overflow, drain, pop-on-empty.
    do_reset("rst2");
    for (int i = 0; i < 5; i++) step("ovf_push", 1, 0, 0, 1, 0);
    cmp("ovf.top14", ras_top, 32'h14);
    for (int i = 0; i < 5; i++) step("ovf_pop", 1, 0, 0, 0, 1);
    cmp("ovf.top0", ras_top, 32'h0);

    // Push+pop replace, non-empty then empty.
    do_reset("rst3");
    step("s4", 1, 0, 0, 0, 0);
    step("push8", 1, 0, 0, 1, 0);
    step("b30", 1, 1, 32'h30, 0, 0);
    step("pp_full", 1, 0, 0, 1, 1);
    cmp("pp.top34", ras_top, 32'h34);
    step("pop_all", 1, 0, 0, 0, 1);
    step("pp_empty", 1, 0, 0, 1, 1);

    // Wrap and mid-cycle asynchronous reset.
    step("bwrap", 1, 1, 32'hFFFF_FFFC, 1, 0);
    step("wrap", 1, 0, 0, 1, 0);
    cmp("wrap.pc0", pc, 32'h0);
    step("bmis", 1, 1, 32'h7, 0, 0);
    do_reset("async");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  s;
      logic [31:0] t;
      s = $urandom_range(0, 9) < 5 ? 2'd0 : 2'($urandom_range(1, 3));
      t = ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      step("rnd", $urandom_range(0, 5) != 0, s, t, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
